maxterm_sweeper: RTL

Sequential truth-table capture engine for 4-input combinational functions. On `start` it walks input indices 0..15 (x = MSB, z = LSB) on outputs `x`, `y`, `w`, `z`. For each index it samples the function output `s` and builds the function's maxterm mask, where bit i = 1 when s = 0. It compares the mask against a caller-supplied expected maxterm list and reports the result. It sits on the reading end of a reduced-function circuit and replaces hand-written index sequences in checking.

---
 rtl/sweep_pkg.sv | 19 +
 rtl/settle_timer.sv | 42 ++++
 rtl/maxterm_sweeper.sv | 138 +++++++++++++
 3 files changed

// File: rtl/sweep_pkg.sv
// Shared types and sizes for the truth-table sweepers.
package sweep_pkg;

   localparam int unsigned N_VARS  = 4;
   localparam int unsigned N_TERMS = 16;
   localparam int unsigned CNT_W   = 5;
   localparam int unsigned TMR_W   = 4;

   typedef logic [N_TERMS-1:0] mask_t;
   typedef logic [N_VARS-1:0]  idx_t;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DRIVE  = 2'd1,
      SAMPLE = 2'd2,
      FIN    = 2'd3
   } state_t;

endpackage

// File: rtl/settle_timer.sv
// Loadable down-counter; expired rises when the count reaches zero.
module settle_timer
   import sweep_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [TMR_W-1:0] load_val,
   input  logic             en,
   output logic             expired
);

   logic [TMR_W-1:0] cnt_q, cnt_d;
   logic             expired_q, expired_d;

   // Load takes priority; otherwise count down while enabled until zero.
   always_comb begin
      cnt_d     = cnt_q;
      expired_d = expired_q;
      if (load) begin
         cnt_d     = load_val;
         expired_d = (load_val == '0);
      end else if (en && (cnt_q != '0)) begin
         cnt_d     = cnt_q - TMR_W'(1);
         expired_d = (cnt_d == '0);
      end
   end

   // Counter and flag registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q     <= '0;
         expired_q <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         expired_q <= expired_d;
      end
   end

   assign expired = expired_q;

endmodule

// File: rtl/maxterm_sweeper.sv
// Walks a 4-input function through all 16 indices, captures its maxterm
// mask and compares it against an expected mask.
module maxterm_sweeper
   import sweep_pkg::*;
#(
   parameter int unsigned SETTLE = 1
)(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [15:0]      expected,
   input  logic             s,
   output logic             x,
   output logic             y,
   output logic             w,
   output logic             z,
   output logic             busy,
   output logic             done,
   output logic [15:0]      maxterms,
   output logic [4:0]       mismatch_cnt,
   output logic [3:0]       first_bad,
   output logic             pass
);

   localparam logic [TMR_W-1:0] SETTLE_LD = TMR_W'(SETTLE - 1);

   state_t           state_q, state_d;
   idx_t             idx_q, idx_d;
   mask_t            exp_q, exp_d;
   mask_t            mask_q, mask_d;
   logic [CNT_W-1:0] mm_q, mm_d;
   idx_t             fb_q, fb_d;
   logic             pass_q, pass_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             tmr_load_c;
   logic             tmr_expired;

   settle_timer u_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (tmr_load_c),
      .load_val (SETTLE_LD),
      .en       (state_q == DRIVE),
      .expired  (tmr_expired)
   );

   // Next-state and datapath updates for the sweep.
   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      exp_d      = exp_q;
      mask_d     = mask_q;
      mm_d       = mm_q;
      fb_d       = fb_q;
      pass_d     = pass_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      tmr_load_c = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               state_d    = DRIVE;
               idx_d      = '0;
               exp_d      = expected;
               mask_d     = '0;
               mm_d       = '0;
               fb_d       = '0;
               pass_d     = 1'b0;
               busy_d     = 1'b1;
               tmr_load_c = 1'b1;
            end
         end
         DRIVE: begin
            if (tmr_expired) state_d = SAMPLE;
         end
         SAMPLE: begin
            mask_d[idx_q] = ~s;
            if ((~s) != exp_q[idx_q]) begin
               mm_d = mm_q + CNT_W'(1);
               if (mm_q == '0) fb_d = idx_q;
            end
            if (idx_q == idx_t'(N_TERMS - 1)) begin
               state_d = FIN;
               idx_d   = '0;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               pass_d  = (mm_d == '0);
            end else begin
               state_d    = DRIVE;
               idx_d      = idx_q + idx_t'(1);
               tmr_load_c = 1'b1;
            end
         end
         FIN: begin
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // State and result registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         idx_q   <= '0;
         exp_q   <= '0;
         mask_q  <= '0;
         mm_q    <= '0;
         fb_q    <= '0;
         pass_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         exp_q   <= exp_d;
         mask_q  <= mask_d;
         mm_q    <= mm_d;
         fb_q    <= fb_d;
         pass_q  <= pass_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign x            = idx_q[3];
   assign y            = idx_q[2];
   assign w            = idx_q[1];
   assign z            = idx_q[0];
   assign busy         = busy_q;
   assign done         = done_q;
   assign maxterms     = mask_q;
   assign mismatch_cnt = mm_q;
   assign first_bad    = fb_q;
   assign pass         = pass_q;

endmodule
